// File: rtl/adc_bridge_pkg.sv
// Shared definitions for the ADC serial bridge.
// Contents:
//   FRAME_HDR / FRAME_TRL - two-bit markers at the low / high end of a frame
//   frame_w()             - serial result frame width for a given result width
//   cfg_sr_w()            - config shift register width (config words + select bit)
package adc_bridge_pkg;

  // Bit 0 of the frame leaves first, so the header reads 1,0 on the wire
  // and the trailer reads 0,1.
  localparam logic [1:0] FRAME_HDR = 2'b01;
  localparam logic [1:0] FRAME_TRL = 2'b10;

  // header(2) + result + vld + ovf + par + trailer(2)
  function automatic int frame_w(input int res_w);
    return res_w + 7;
  endfunction

  // All config words plus the finish-select bit on top.
  function automatic int cfg_sr_w(input int ncfg, input int cfg_w);
    return ncfg * cfg_w + 1;
  endfunction

endpackage

// File: rtl/adc_res_fifo.sv
// Result FIFO, DEPTH entries of RES_W bits. Storage is not reset; only the
// pointers and the occupancy count are.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   push, wdata  - write request and data; ignored when full unless a pop
//                  happens in the same cycle (the freed slot is reused)
//   pop, rdata   - read request; rdata always shows the current head
//   full, empty  - occupancy flags
//   count        - number of stored entries (0..DEPTH)
module adc_res_fifo #(
  parameter int RES_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [RES_W-1:0]         wdata,
  input  logic                     pop,
  output logic [RES_W-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [RES_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A full FIFO can still accept a write when the head leaves this cycle.
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
    // naturally.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/adc_serial_bridge.sv
// Serial bridge between a host and an ADC.
//  - Config path: dat_i shifts LSB-first into a shift register; the first
//    load rising edge after reset commits it to the config store.
//  - Result path: the selected finish flag is synchronized and
//    edge-detected; each edge captures adc_res into a FIFO. Each load rising
//    edge pops the head into a frame shifted out LSB-first on dat_o.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   dat_i                  - serial config in
//   load                   - load strobe (acted on at its rising edge)
//   adc_res                - ADC result
//   adc_conv_finished(_osr)- finish flags from the ADC (asynchronous)
//   adc_cfg                - stored config words
//   dat_o                  - serial result frame out
//   conv_finish            - selected raw finish flag
//   data_avail             - result FIFO not empty
//   cfg_locked             - config committed since reset
//   tie1, tie0             - constants
module adc_serial_bridge
  import adc_bridge_pkg::*;
#(
  parameter int RES_W = 16,
  parameter int CFG_W = 16,
  parameter int NCFG  = 2,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dat_i,
  input  logic                    load,
  input  logic [RES_W-1:0]        adc_res,
  input  logic                    adc_conv_finished,
  input  logic                    adc_conv_finished_osr,
  output logic [NCFG*CFG_W-1:0]   adc_cfg,
  output logic                    dat_o,
  output logic                    conv_finish,
  output logic                    data_avail,
  output logic                    cfg_locked,
  output logic                    tie1,
  output logic                    tie0
);

  localparam int FRAME_W  = frame_w(RES_W);
  localparam int CFG_SR_W = cfg_sr_w(NCFG, CFG_W);
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic [CFG_SR_W-1:0] cfg_sr_q, cfg_sr_d;
  logic [CFG_SR_W-1:0] store_q, store_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic                load_q, load_d;
  logic                cfg_locked_q, cfg_locked_d;
  logic                ovf_q, ovf_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                sync3_q, sync3_d;

  logic                load_rise, capture, pop, ovf_set;
  logic                head_vld;
  logic [RES_W-1:0]    head_res;
  logic [FRAME_W-1:0]  frame_new;
  logic [RES_W-1:0]    fifo_rdata;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  // Top bit of the store picks which finish flag is forwarded: 0 -> OSR.
  assign conv_finish = store_q[CFG_SR_W-1] ? adc_conv_finished : adc_conv_finished_osr;

  always_comb begin
    load_rise = load && !load_q;
    // sync1/sync2 are the synchronizer; sync3 holds the previous synchronized
    // value for the rising-edge detect.
    capture   = sync2_q && !sync3_q;
    pop       = load_rise && !fifo_empty;
    // A capture into a full FIFO survives if the head leaves the same cycle.
    ovf_set   = capture && fifo_full && !pop;
    head_vld  = !fifo_empty;
    head_res  = fifo_empty ? '0 : fifo_rdata;
    frame_new = {FRAME_TRL, ^{ovf_q, head_vld, head_res}, ovf_q, head_vld, head_res, FRAME_HDR};

    sync1_d      = conv_finish;
    sync2_d      = sync1_q;
    sync3_d      = sync2_q;
    load_d       = load;
    cfg_sr_d     = cfg_sr_q;
    store_d      = store_q;
    frame_d      = frame_q;
    cfg_locked_d = cfg_locked_q;
    ovf_d        = ovf_q | ovf_set;

    if (load_rise) begin
      frame_d      = frame_new;
      cfg_locked_d = 1'b1;
      if (!cfg_locked_q) store_d = cfg_sr_q;
      // The reported flag is consumed; only an overflow in this very cycle
      // survives.
      ovf_d = ovf_set;
    end

    // Both registers freeze while load is high.
    if (!load) begin
      cfg_sr_d = {dat_i, cfg_sr_q[CFG_SR_W-1:1]};
      frame_d  = {1'b0, frame_q[FRAME_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_sr_q     <= '0;
      store_q      <= '0;
      frame_q      <= '0;
      load_q       <= 1'b0;
      cfg_locked_q <= 1'b0;
      ovf_q        <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
    end else begin
      cfg_sr_q     <= cfg_sr_d;
      store_q      <= store_d;
      frame_q      <= frame_d;
      load_q       <= load_d;
      cfg_locked_q <= cfg_locked_d;
      ovf_q        <= ovf_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
    end
  end

  adc_res_fifo #(
    .RES_W (RES_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture),
    .wdata (adc_res),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign adc_cfg    = store_q[CFG_SR_W-2:0];
  assign dat_o      = frame_q[0];
  assign data_avail = (fifo_count != '0);
  assign cfg_locked = cfg_locked_q;
  assign tie1       = 1'b1;
  assign tie0       = 1'b0;

endmodule
